// File: rtl/easy_axi_rd_arb_pkg.sv
// Shared AXI widths, encodings and arbiter state type
// for the easy_axi read-path blocks.
package easy_axi_rd_arb_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_1B = 3'd0;
    localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_2B = 3'd1;
    localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_4B = 3'd2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_ADDR = 2'd1,
        ARB_ST_DATA = 2'd2
    } arb_st_e;

endpackage

// File: rtl/easy_axi_rr_pick.sv
// Combinational round-robin picker: first requester above
// 'last', wrapping modulo NUM_MST.
module easy_axi_rr_pick #(
    parameter int NUM_MST = 2,
    parameter int GIDX_W  = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [GIDX_W-1:0]  last,
    output logic [NUM_MST-1:0] gnt_onehot,
    output logic [GIDX_W-1:0]  gnt_idx,
    output logic               any
);

    logic [GIDX_W-1:0] w_j;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        w_j        = '0;
        // k runs to NUM_MST so 'last' itself is the final candidate
        for (int k = 1; k <= NUM_MST; k++) begin
            w_j = GIDX_W'((int'(last) + k) % NUM_MST);
            if (!any && req[w_j]) begin
                any            = 1'b1;
                gnt_onehot[w_j] = 1'b1;
                gnt_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/easy_axi_rd_arb.sv
// Round-robin arbiter sharing one downstream AXI read port
// between NUM_MST masters; one burst in flight at a time.
module easy_axi_rd_arb
    import easy_axi_rd_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int GIDX_W  = $clog2(NUM_MST)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MST-1:0]             m_arvalid,
    output logic [NUM_MST-1:0]             m_arready,
    input  logic [NUM_MST*AXI_ID_W-1:0]    m_arid,
    input  logic [NUM_MST*AXI_ADDR_W-1:0]  m_araddr,
    input  logic [NUM_MST*AXI_LEN_W-1:0]   m_arlen,
    input  logic [NUM_MST*AXI_SIZE_W-1:0]  m_arsize,
    input  logic [NUM_MST*AXI_BURST_W-1:0] m_arburst,
    output logic [NUM_MST-1:0]             m_rvalid,
    input  logic [NUM_MST-1:0]             m_rready,
    output logic [AXI_DATA_W-1:0]          m_rdata,
    output logic [AXI_RESP_W-1:0]          m_rresp,
    output logic                           m_rlast,
    output logic                           s_arvalid,
    input  logic                           s_arready,
    output logic [AXI_ID_W-1:0]            s_arid,
    output logic [AXI_ADDR_W-1:0]          s_araddr,
    output logic [AXI_LEN_W-1:0]           s_arlen,
    output logic [AXI_SIZE_W-1:0]          s_arsize,
    output logic [AXI_BURST_W-1:0]         s_arburst,
    input  logic                           s_rvalid,
    output logic                           s_rready,
    input  logic [AXI_DATA_W-1:0]          s_rdata,
    input  logic [AXI_RESP_W-1:0]          s_rresp,
    input  logic                           s_rlast,
    output logic                           busy,
    output logic [GIDX_W-1:0]              grant_idx,
    output logic                           len_err
);

    arb_st_e                r_state;
    arb_st_e                w_next;
    logic [GIDX_W-1:0]      r_grant;
    logic [GIDX_W-1:0]      r_last;
    logic [AXI_LEN_W:0]     r_beat_cnt;
    logic                   r_len_err;
    logic [AXI_ID_W-1:0]    r_arid;
    logic [AXI_ADDR_W-1:0]  r_araddr;
    logic [AXI_LEN_W-1:0]   r_arlen;
    logic [AXI_SIZE_W-1:0]  r_arsize;
    logic [AXI_BURST_W-1:0] r_arburst;

    logic [NUM_MST-1:0]     w_pick_onehot;
    logic [GIDX_W-1:0]      w_pick_idx;
    logic                   w_pick_any;
    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_len_hit;

    easy_axi_rr_pick #(
        .NUM_MST (NUM_MST),
        .GIDX_W  (GIDX_W)
    ) u_pick (
        .req        (m_arvalid),
        .last       (r_last),
        .gnt_onehot (w_pick_onehot),
        .gnt_idx    (w_pick_idx),
        .any        (w_pick_any)
    );

    // The picked master is valid by construction, so 'any' is the handshake
    assign w_ar_hs   = (r_state == ARB_ST_IDLE) && w_pick_any;
    assign w_r_hs    = (r_state == ARB_ST_DATA) && s_rvalid && s_rready;
    assign w_len_hit = (r_beat_cnt == {1'b0, r_arlen});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        m_arready = '0;
        m_rvalid  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (r_state)
            ARB_ST_IDLE: begin
                m_arready = w_pick_onehot;
                if (w_pick_any) begin
                    w_next = ARB_ST_ADDR;
                end
            end
            ARB_ST_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    w_next = ARB_ST_DATA;
                end
            end
            ARB_ST_DATA: begin
                s_rready          = m_rready[r_grant];
                m_rvalid[r_grant] = s_rvalid;
                if (s_rvalid && m_rready[r_grant] && s_rlast) begin
                    w_next = ARB_ST_IDLE;
                end
            end
            default: begin
                w_next = ARB_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_last     <= GIDX_W'(NUM_MST - 1);
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
            r_arid     <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arburst  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_grant    <= w_pick_idx;
                r_beat_cnt <= '0;
                r_arid     <= m_arid[w_pick_idx*AXI_ID_W +: AXI_ID_W];
                r_araddr   <= m_araddr[w_pick_idx*AXI_ADDR_W +: AXI_ADDR_W];
                r_arlen    <= m_arlen[w_pick_idx*AXI_LEN_W +: AXI_LEN_W];
                r_arsize   <= m_arsize[w_pick_idx*AXI_SIZE_W +: AXI_SIZE_W];
                r_arburst  <= m_arburst[w_pick_idx*AXI_BURST_W +: AXI_BURST_W];
            end
            // A mismatch is flagged at whichever end of the burst notices it
            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (s_rlast) begin
                    r_last <= r_grant;
                    if (!w_len_hit) begin
                        r_len_err <= 1'b1;
                    end
                end else if (w_len_hit) begin
                    r_len_err <= 1'b1;
                end
            end
        end
    end

    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;
    assign s_arid    = r_arid;
    assign s_araddr  = r_araddr;
    assign s_arlen   = r_arlen;
    assign s_arsize  = r_arsize;
    assign s_arburst = r_arburst;
    assign busy      = (r_state != ARB_ST_IDLE);
    assign grant_idx = r_grant;
    assign len_err   = r_len_err;

endmodule

// File: tb/tb_easy_axi_rd_arb.sv
// Randomized bench for easy_axi_rd_arb against a
// transaction-level arbiter/slave reference model.
module tb_easy_axi_rd_arb;
    import easy_axi_rd_arb_pkg::*;

    localparam int N  = 2;
    localparam int GW = 1;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic [N-1:0]               m_arvalid;
    logic [N-1:0]               m_arready;
    logic [N*AXI_ID_W-1:0]      m_arid;
    logic [N*AXI_ADDR_W-1:0]    m_araddr;
    logic [N*AXI_LEN_W-1:0]     m_arlen;
    logic [N*AXI_SIZE_W-1:0]    m_arsize;
    logic [N*AXI_BURST_W-1:0]   m_arburst;
    logic [N-1:0]               m_rvalid;
    logic [N-1:0]               m_rready;
    logic [AXI_DATA_W-1:0]      m_rdata;
    logic [AXI_RESP_W-1:0]      m_rresp;
    logic                       m_rlast;
    logic                       s_arvalid;
    logic                       s_arready;
    logic [AXI_ID_W-1:0]        s_arid;
    logic [AXI_ADDR_W-1:0]      s_araddr;
    logic [AXI_LEN_W-1:0]       s_arlen;
    logic [AXI_SIZE_W-1:0]      s_arsize;
    logic [AXI_BURST_W-1:0]     s_arburst;
    logic                       s_rvalid;
    logic                       s_rready;
    logic [AXI_DATA_W-1:0]      s_rdata;
    logic [AXI_RESP_W-1:0]      s_rresp;
    logic                       s_rlast;
    logic                       busy;
    logic [GW-1:0]              grant_idx;
    logic                       len_err;

    easy_axi_rd_arb #(.NUM_MST(N), .GIDX_W(GW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .busy(busy), .grant_idx(grant_idx), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: one burst owner, its progress, sticky error
    bit               md_busy, md_addr_done, md_err;
    int               md_grant, md_last, md_gidx, md_beats, md_len;
    logic [AXI_ID_W-1:0]    md_arid;
    logic [AXI_ADDR_W-1:0]  md_araddr;
    logic [AXI_LEN_W-1:0]   md_arlen;
    logic [AXI_SIZE_W-1:0]  md_arsize;
    logic [AXI_BURST_W-1:0] md_arburst;

    // upstream masters
    int                     rq_rem[N];
    int                     rq_start[N];
    logic [AXI_ADDR_W-1:0]  rq_addr[N];
    logic [AXI_LEN_W-1:0]   rq_len[N];
    logic [AXI_ID_W-1:0]    rq_id[N];

    // downstream slave
    int  sl_delay, sl_idx, sl_last_at;
    bit  sl_rvalid;

    // scenario knobs
    int  rr_mode, plan_delay, plan_rlast, cyc;
    bit  rand_rv, stray, rand_len, rand_gap;

    // per-cycle events
    int  ev_ar;
    bit  ev_sar, ev_r, ev_rlast;
    bit  prev_busy;
    int  glog[$];
    logic [AXI_DATA_W-1:0] rlog[$];

    task automatic drive();
        for (int m = 0; m < N; m++) begin
            m_arvalid[m] = (rq_rem[m] > 0) && (cyc >= rq_start[m]);
            m_arid[m*AXI_ID_W +: AXI_ID_W]          = rq_id[m];
            m_araddr[m*AXI_ADDR_W +: AXI_ADDR_W]    = rq_addr[m];
            m_arlen[m*AXI_LEN_W +: AXI_LEN_W]       = rq_len[m];
            m_arsize[m*AXI_SIZE_W +: AXI_SIZE_W]    = AXI_SIZE_4B;
            m_arburst[m*AXI_BURST_W +: AXI_BURST_W] = AXI_BURST_INCR;
        end
        case (rr_mode)
            0:       m_rready = 2'b11;
            1:       m_rready = (cyc % 2 == 0) ? 2'b11 : 2'b00;
            default: m_rready = 2'($urandom);
        endcase
        if (md_busy && !md_addr_done) s_arready = (sl_delay == 0);
        else                          s_arready = 1'($urandom);
        if (md_busy && md_addr_done) begin
            if (!sl_rvalid) sl_rvalid = rand_rv ? ($urandom % 4 != 0) : 1'b1;
            s_rvalid = sl_rvalid;
            s_rdata  = 32'hA0 + 32'(sl_idx);
            s_rlast  = (sl_idx == sl_last_at);
            s_rresp  = 2'(sl_idx);
        end else begin
            s_rvalid = stray ? 1'($urandom) : 1'b0;
            s_rdata  = $urandom;
            s_rlast  = 1'($urandom);
            s_rresp  = 2'($urandom);
        end
    endtask

    task automatic check_cycle();
        int w;
        logic [N-1:0] exp_arready, exp_rvalid;
        bit exp_sarv, exp_srr;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (md_last + k) % N;
            if (w < 0 && m_arvalid[j]) w = j;
        end
        exp_arready = (!md_busy && w >= 0) ? N'(1 << w) : '0;
        exp_sarv    = md_busy && !md_addr_done;
        exp_rvalid  = (md_busy && md_addr_done && s_rvalid) ? N'(1 << md_grant) : '0;
        exp_srr     = md_busy && md_addr_done && m_rready[md_grant];
        checks++;
        if (m_arready !== exp_arready) begin
            errors++;
            $display("FAIL m_arready cyc=%0d got=%b want=%b", cyc, m_arready, exp_arready);
        end
        checks++;
        if (s_arvalid !== exp_sarv) begin
            errors++;
            $display("FAIL s_arvalid cyc=%0d got=%b want=%b", cyc, s_arvalid, exp_sarv);
        end
        checks++;
        if ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst} !==
            {md_arid, md_araddr, md_arlen, md_arsize, md_arburst}) begin
            errors++;
            $display("FAIL s_ar_payload cyc=%0d got=%h/%h/%h want=%h/%h/%h",
                     cyc, s_arid, s_araddr, s_arlen, md_arid, md_araddr, md_arlen);
        end
        checks++;
        if (m_rvalid !== exp_rvalid) begin
            errors++;
            $display("FAIL m_rvalid cyc=%0d got=%b want=%b", cyc, m_rvalid, exp_rvalid);
        end
        checks++;
        if (s_rready !== exp_srr) begin
            errors++;
            $display("FAIL s_rready cyc=%0d got=%b want=%b", cyc, s_rready, exp_srr);
        end
        checks++;
        if ({busy, grant_idx, len_err} !== {md_busy, GW'(md_gidx), md_err}) begin
            errors++;
            $display("FAIL status cyc=%0d got busy=%b gnt=%0d err=%b want %b/%0d/%b",
                     cyc, busy, grant_idx, len_err, md_busy, md_gidx, md_err);
        end
        checks++;
        if ({m_rdata, m_rresp, m_rlast} !== {s_rdata, s_rresp, s_rlast}) begin
            errors++;
            $display("FAIL r_mirror cyc=%0d got=%h want=%h", cyc, m_rdata, s_rdata);
        end
        ev_ar    = (exp_arready != '0) ? w : -1;
        ev_sar   = exp_sarv && s_arready;
        ev_r     = exp_srr && s_rvalid;
        ev_rlast = s_rlast;
        if (busy && !prev_busy) glog.push_back(int'(grant_idx));
        prev_busy = busy;
        for (int m = 0; m < N; m++)
            if (m_rvalid[m] && m_rready[m]) rlog.push_back(m_rdata);
    endtask

    task automatic update();
        int w;
        w = ev_ar;
        if (w >= 0) begin
            md_busy      = 1'b1;
            md_addr_done = 1'b0;
            md_grant     = w;
            md_gidx      = w;
            md_arid      = rq_id[w];
            md_araddr    = rq_addr[w];
            md_arlen     = rq_len[w];
            md_arsize    = AXI_SIZE_4B;
            md_arburst   = AXI_BURST_INCR;
            md_len       = int'(rq_len[w]);
            md_beats     = 0;
            sl_delay     = (plan_delay >= 0) ? plan_delay : int'($urandom % 3);
            sl_idx       = 0;
            sl_rvalid    = 1'b0;
            sl_last_at   = (plan_rlast >= 0) ? plan_rlast : md_len;
            rq_rem[w]--;
            rq_addr[w] += 32'h40;
            rq_id[w]++;
            if (rand_len) rq_len[w] = 8'($urandom % 8);
            if (rand_gap) rq_start[w] = cyc + 1 + int'($urandom % 3);
        end else if (md_busy && !md_addr_done) begin
            if (ev_sar) md_addr_done = 1'b1;
            else if (sl_delay > 0) sl_delay--;
        end else if (ev_r) begin
            if (ev_rlast) begin
                if (md_beats != md_len) md_err = 1'b1;
                md_busy = 1'b0;
                md_last = md_grant;
            end else if (md_beats == md_len) begin
                md_err = 1'b1;
            end
            md_beats++;
            sl_idx++;
            sl_rvalid = 1'b0;
        end
        cyc++;
    endtask

    task automatic one_cycle();
        drive();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic run_idle(input int maxc, input string name);
        int n;
        n = 0;
        while ((rq_rem[0] > 0 || rq_rem[1] > 0 || md_busy) && n < maxc) begin
            one_cycle();
            n++;
        end
        checks++;
        if (rq_rem[0] > 0 || rq_rem[1] > 0 || md_busy) begin
            errors++;
            $display("FAIL %s_timeout got=busy want=idle within %0d cycles", name, maxc);
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        m_arvalid = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rlast   = 1'b1;
        s_rdata   = '0;
        s_rresp   = '0;
        md_busy = 0; md_addr_done = 0; md_err = 0;
        md_grant = 0; md_gidx = 0; md_last = N - 1; md_beats = 0; md_len = 0;
        md_arid = '0; md_araddr = '0; md_arlen = '0; md_arsize = '0; md_arburst = '0;
        for (int m = 0; m < N; m++) begin
            rq_rem[m] = 0; rq_start[m] = 0; rq_addr[m] = '0;
            rq_len[m] = '0; rq_id[m] = AXI_ID_W'(m * 4);
        end
        sl_delay = 0; sl_idx = 0; sl_last_at = 0; sl_rvalid = 0;
        rr_mode = 0; plan_delay = 0; plan_rlast = -1; cyc = 0;
        rand_rv = 0; stray = 0; rand_len = 0; rand_gap = 0;
        prev_busy = 0;
        glog.delete();
        rlog.delete();
        #1;
        checks++;
        if ({s_arvalid, s_rready, m_arready, m_rvalid, busy, grant_idx, len_err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got arv=%b rr=%b ar=%b rv=%b busy=%b g=%0d err=%b want 0",
                     s_arvalid, s_rready, m_arready, m_rvalid, busy, grant_idx, len_err);
        end
        checks++;
        if ({s_arid, s_araddr, s_arlen, s_arsize, s_arburst} !== '0) begin
            errors++;
            $display("FAIL reset_payload got=%h want=0", s_araddr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        stray      = 1;
        plan_delay = 2;
        rq_rem[0]  = 1;
        rq_addr[0] = 32'h100;
        rq_len[0]  = 8'd3;
        run_idle(60, "single");
        checks++;
        if (rlog.size() != 4 || glog.size() != 1) begin
            errors++;
            $display("FAIL single_beats got=%0d/%0d want=4/1", rlog.size(), glog.size());
        end
    endtask

    task automatic test_alternate();
        apply_reset();
        plan_delay = 1;
        rq_rem[0] = 2; rq_len[0] = 8'd1; rq_addr[0] = 32'h1000;
        rq_rem[1] = 2; rq_len[1] = 8'd2; rq_addr[1] = 32'h2000;
        run_idle(100, "alternate");
        checks++;
        if (glog.size() != 4) begin
            errors++;
            $display("FAIL alt_count got=%0d want=4", glog.size());
        end
        for (int i = 0; i < glog.size() && i < 4; i++) begin
            checks++;
            if (glog[i] != i % 2) begin
                errors++;
                $display("FAIL alt_order[%0d] got=%0d want=%0d", i, glog[i], i % 2);
            end
        end
    endtask

    task automatic test_wait_busy();
        apply_reset();
        rq_rem[0] = 1; rq_len[0] = 8'd3; rq_addr[0] = 32'h300;
        rq_rem[1] = 1; rq_len[1] = 8'd0; rq_addr[1] = 32'h400;
        rq_start[1] = 4;
        run_idle(60, "wait_busy");
        checks++;
        if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1) begin
            errors++;
            $display("FAIL wait_busy_order got n=%0d want 0,1", glog.size());
        end
    endtask

    task automatic test_len_err();
        apply_reset();
        rq_rem[0] = 1; rq_len[0] = 8'd1; plan_rlast = 0;
        run_idle(40, "early_rlast");
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL early_rlast_err got=%b want=1", len_err);
        end
        plan_rlast = -1;
        rq_rem[0]  = 1;
        run_idle(40, "sticky");
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL sticky_err got=%b want=1", len_err);
        end
        apply_reset();
        rq_rem[0] = 1; rq_len[0] = 8'd0; plan_rlast = 1;
        run_idle(40, "late_rlast");
        checks++;
        if (len_err !== 1'b1 || rlog.size() != 2) begin
            errors++;
            $display("FAIL late_rlast got err=%b beats=%0d want 1/2", len_err, rlog.size());
        end
    endtask

    task automatic test_ready_toggle();
        apply_reset();
        rr_mode = 1;
        rq_rem[0] = 1; rq_len[0] = 8'd3; rq_addr[0] = 32'h500;
        run_idle(60, "toggle");
        checks++;
        if (rlog.size() != 4) begin
            errors++;
            $display("FAIL toggle_count got=%0d want=4", rlog.size());
        end
        for (int i = 0; i < rlog.size() && i < 4; i++) begin
            checks++;
            if (rlog[i] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL toggle_data[%0d] got=%h want=%h", i, rlog[i], 32'hA0 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        rq_rem[0] = 1; rq_len[0] = 8'd7; rq_addr[0] = 32'h600;
        n = 0;
        while (!(md_addr_done && md_beats >= 2) && n < 40) begin
            one_cycle();
            n++;
        end
        checks++;
        if (!(md_addr_done && md_beats >= 2)) begin
            errors++;
            $display("FAIL mid_reach got beats=%0d want>=2", md_beats);
        end
        #2;
        apply_reset();
        rq_rem[1] = 1; rq_len[1] = 8'd2; rq_addr[1] = 32'h700;
        run_idle(40, "post_reset");
        checks++;
        if (glog.size() != 1 || glog[0] != 1 || rlog.size() != 3) begin
            errors++;
            $display("FAIL post_reset got grants=%0d beats=%0d want 1/3", glog.size(), rlog.size());
        end
    endtask

    task automatic test_random();
        apply_reset();
        rr_mode = 2; rand_rv = 1; stray = 1;
        rand_len = 1; rand_gap = 1; plan_delay = -1;
        for (int m = 0; m < N; m++) begin
            rq_rem[m]   = 3 + int'($urandom % 4);
            rq_len[m]   = 8'($urandom % 8);
            rq_addr[m]  = 32'($urandom) & 32'hFFFF_FFC0;
            rq_start[m] = int'($urandom % 5);
        end
        run_idle(3000, "random");
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_alternate();
        test_wait_busy();
        test_len_err();
        test_ready_toggle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
